// File: rtl/lab2_proc_mem_responder.sv
// ---------------------------------------------------------------------------
// lab2_proc_mem_responder
//
// Single-outstanding-request memory responder backed by a word-organised
// array of p_mem_nwords 32-bit words. A request is accepted in IDLE. The
// responder then waits p_latency cycles and presents the response in RESP
// until the consumer takes it. Sub-word accesses select byte lanes
// addr[1:0] .. min(addr[1:0]+n,4)-1. Bytes that would cross the word
// boundary are dropped. Read data is captured at the acceptance edge.
//
// Ports
//   clk             : clock, all state updates on the rising edge
//   reset           : asynchronous, active-low reset
//   reqstream_val   : request valid
//   reqstream_rdy   : responder can accept a request (IDLE only)
//   reqstream_msg   : request {type_, opaque, addr, len, data}
//   respstream_val  : response valid (RESP only)
//   respstream_rdy  : consumer accepts the response
//   respstream_msg  : response {type_, opaque, test, len, data}
// ---------------------------------------------------------------------------
package lab2_proc_mem_pkg;

   typedef struct packed {
      logic [2:0]  type_;    // 0 = read, 1 = write, others read
      logic [7:0]  opaque;
      logic [31:0] addr;
      logic [1:0]  len;      // 0 encodes a full 4-byte access
      logic [31:0] data;
   } mem_req_4B_t;

   typedef struct packed {
      logic [2:0]  type_;
      logic [7:0]  opaque;
      logic [1:0]  test;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_resp_4B_t;

   localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;

endpackage

module lab2_proc_mem_responder
   import lab2_proc_mem_pkg::*;
#(
   parameter int p_mem_nwords = 256,
   parameter int p_latency    = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         reqstream_val,
   output logic         reqstream_rdy,
   input  mem_req_4B_t  reqstream_msg,
   output logic         respstream_val,
   input  logic         respstream_rdy,
   output mem_resp_4B_t respstream_msg
);

   localparam int         c_idx_w     = $clog2(p_mem_nwords);
   localparam logic [3:0] c_wait_load = (p_latency > 0) ? 4'(p_latency - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t       state, state_next;
   logic [3:0]   cnt, cnt_next;
   mem_resp_4B_t resp_q;

   logic [31:0]  mem [p_mem_nwords];

   // ------------------------------------------------------------------
   // Request decode: word index, byte offset, active byte lanes
   // ------------------------------------------------------------------
   logic [c_idx_w-1:0] word_idx;
   logic [1:0]         offset;
   logic [2:0]         nbytes;
   logic [3:0]         byte_en;
   logic [31:0]        be_mask;
   logic [31:0]        wdata_shift;
   logic [31:0]        rd_data;
   logic               req_fire;
   logic               is_write;

   // Address bits above the word index are intentionally ignored so the
   // address space wraps modulo the memory size.
   logic unused_addr_bits;
   assign unused_addr_bits = ^reqstream_msg.addr[31:c_idx_w+2];

   assign word_idx = reqstream_msg.addr[c_idx_w+1:2];
   assign offset   = reqstream_msg.addr[1:0];
   assign nbytes   = (reqstream_msg.len == 2'd0) ? 3'd4 : {1'b0, reqstream_msg.len};
   assign req_fire = reqstream_val && reqstream_rdy;
   assign is_write = (reqstream_msg.type_ == MEM_TYPE_WRITE);

   always_comb begin
      byte_en = '0;
      be_mask = '0;
      for (int lane = 0; lane < 4; lane++) begin
         // offset + nbytes never exceeds 7, so a 3-bit sum cannot overflow;
         // lanes past 3 simply do not exist, which drops the overflow bytes.
         byte_en[lane] = (3'(lane) >= {1'b0, offset}) &&
                         (3'(lane) <  ({1'b0, offset} + nbytes));
         be_mask[8*lane +: 8] = {8{byte_en[lane]}};
      end
   end

   // Data byte 0 lands on lane `offset`; lanes outside byte_en are masked.
   assign wdata_shift = reqstream_msg.data << {offset, 3'b000};
   assign rd_data     = (mem[word_idx] & be_mask) >> {offset, 3'b000};

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------
   // NOTE: the array has no reset; contents must survive reset, and
   // clearing a RAM would defeat its mapping onto memory macros.
   always_ff @(posedge clk) begin
      if (req_fire && is_write && reset) begin
         for (int lane = 0; lane < 4; lane++) begin
            if (byte_en[lane]) begin
               mem[word_idx][8*lane +: 8] <= wdata_shift[8*lane +: 8];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Response capture at the acceptance edge; held stable through RESP
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         resp_q <= '0;
      end else if (req_fire) begin
         resp_q.type_  <= reqstream_msg.type_;
         resp_q.opaque <= reqstream_msg.opaque;
         resp_q.test   <= 2'b00;
         resp_q.len    <= reqstream_msg.len;
         resp_q.data   <= is_write ? 32'd0 : rd_data;
      end
   end

   assign respstream_msg = resp_q;

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // NOTE: every output of this block is given a default first so no path
   // leaves a signal unassigned and infers a latch.
   always_comb begin
      state_next     = state;
      cnt_next       = cnt;
      reqstream_rdy  = 1'b0;
      respstream_val = 1'b0;

      case (state)
         ST_IDLE: begin
            reqstream_rdy = 1'b1;
            if (reqstream_val) begin
               if (p_latency == 0) begin
                  state_next = ST_RESP;
               end else begin
                  state_next = ST_WAIT;
                  cnt_next   = c_wait_load;
               end
            end
         end

         ST_WAIT: begin
            if (cnt == 4'd0) begin
               state_next = ST_RESP;
            end else begin
               cnt_next = cnt - 4'd1;
            end
         end

         ST_RESP: begin
            respstream_val = 1'b1;
            if (respstream_rdy) begin
               state_next = ST_IDLE;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_lab2_proc_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_lab2_proc_mem_responder
//
// Drives two responders sharing one clock and reset: index 0 has latency 2
// and index 1 has latency 0. A byte-addressed reference memory predicts
// every response from the request rules alone. Directed steps cover the
// documented scenarios. Random traffic covers the rest.
// ---------------------------------------------------------------------------
module tb_lab2_proc_mem_responder;
   import lab2_proc_mem_pkg::*;

   localparam int NW    = 256;
   localparam int NBYTE = 4 * NW;

   logic         clk = 1'b0;
   logic         reset;
   logic         req_val  [2];
   logic         req_rdy  [2];
   mem_req_4B_t  req_msg  [2];
   logic         resp_val [2];
   logic         resp_rdy [2];
   mem_resp_4B_t resp_msg [2];

   always #5 clk = ~clk;

   lab2_proc_mem_responder #(.p_mem_nwords(NW), .p_latency(2)) u_dut_l2 (
      .clk            (clk),
      .reset          (reset),
      .reqstream_val  (req_val[0]),
      .reqstream_rdy  (req_rdy[0]),
      .reqstream_msg  (req_msg[0]),
      .respstream_val (resp_val[0]),
      .respstream_rdy (resp_rdy[0]),
      .respstream_msg (resp_msg[0])
   );

   lab2_proc_mem_responder #(.p_mem_nwords(NW), .p_latency(0)) u_dut_l0 (
      .clk            (clk),
      .reset          (reset),
      .reqstream_val  (req_val[1]),
      .reqstream_rdy  (req_rdy[1]),
      .reqstream_msg  (req_msg[1]),
      .respstream_val (resp_val[1]),
      .respstream_rdy (resp_rdy[1]),
      .respstream_msg (resp_msg[1])
   );

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: plain byte array, address taken modulo memory size
   // ------------------------------------------------------------------
   logic [7:0] ref_mem [2][NBYTE];

   function automatic int lat(input int s);
      return (s == 0) ? 2 : 0;
   endfunction

   function automatic mem_resp_4B_t model(input int s, input mem_req_4B_t r);
      mem_resp_4B_t rsp;
      int a, o, base, n;
      logic [31:0] d;
      a    = int'(r.addr % 32'(NBYTE));
      o    = a % 4;
      base = a - o;
      n    = (r.len == 2'd0) ? 4 : int'(r.len);
      d    = 32'd0;
      for (int i = 0; i < n; i++) begin
         if (o + i < 4) begin
            if (r.type_ == 3'd1) ref_mem[s][base + o + i] = r.data[8*i +: 8];
            else                 d[8*i +: 8] = ref_mem[s][base + o + i];
         end
      end
      rsp.type_  = r.type_;
      rsp.opaque = r.opaque;
      rsp.test   = 2'b00;
      rsp.len    = r.len;
      rsp.data   = d;
      return rsp;
   endfunction

   function automatic mem_req_4B_t mk(input logic [2:0] t, input logic [7:0] op,
                                      input logic [31:0] a, input logic [1:0] l,
                                      input logic [31:0] d);
      mem_req_4B_t r;
      r.type_  = t;
      r.opaque = op;
      r.addr   = a;
      r.len    = l;
      r.data   = d;
      return r;
   endfunction

   function automatic mem_req_4B_t rand_req();
      logic [2:0] t;
      t = ($urandom_range(0, 7) == 7) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
      return mk(t, 8'($urandom), 32'($urandom), 2'($urandom), 32'($urandom));
   endfunction

   // ------------------------------------------------------------------
   // Transaction helpers
   // ------------------------------------------------------------------
   task automatic wait_req_rdy(input int s, input string tag);
      int cyc = 0;
      while (req_rdy[s] !== 1'b1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, ":req_rdy"}, 64'(req_rdy[s]), 64'd1);
   endtask

   // One complete request/response with optional response backpressure.
   task automatic txn(input int s, input mem_req_4B_t r, input int stall,
                      input string tag, output mem_resp_4B_t got);
      mem_resp_4B_t exp;
      int cyc;
      @(negedge clk);
      req_val[s] = 1'b1;
      req_msg[s] = r;
      wait_req_rdy(s, tag);
      exp = model(s, r);
      @(posedge clk);
      #1;
      req_val[s]       = 1'b0;
      req_msg[s].addr  = 32'($urandom);
      req_msg[s].data  = 32'($urandom);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (resp_val[s] !== 1'b1 && cyc < 50);
      check({tag, ":latency"}, 64'(cyc), 64'(lat(s) + 1));
      got = resp_msg[s];
      check({tag, ":resp"}, 64'(got), 64'(exp));
      for (int k = 0; k < stall; k++) begin
         @(negedge clk);
         check({tag, ":stall_val"}, 64'(resp_val[s]), 64'd1);
         check({tag, ":stall_msg"}, 64'(resp_msg[s]), 64'(exp));
         check({tag, ":stall_req_rdy"}, 64'(req_rdy[s]), 64'd0);
      end
      resp_rdy[s] = 1'b1;
      @(posedge clk);
      #1;
      resp_rdy[s] = 1'b0;
      check({tag, ":idle_req_rdy"}, 64'(req_rdy[s]), 64'd1);
      check({tag, ":idle_resp_val"}, 64'(resp_val[s]), 64'd0);
   endtask

   // Accept a request on responder 0, then reset while it is in WAIT.
   task automatic abort_in_wait(input mem_req_4B_t r, input string tag);
      mem_resp_4B_t dummy;
      int seen;
      @(negedge clk);
      req_val[0] = 1'b1;
      req_msg[0] = r;
      wait_req_rdy(0, tag);
      dummy = model(0, r);
      @(posedge clk);
      #1;
      req_val[0] = 1'b0;
      @(negedge clk);
      check({tag, ":in_wait"}, 64'(req_rdy[0]), 64'd0);
      #2;
      reset = 1'b0;
      #1;
      check({tag, ":rst_req_rdy"}, 64'(req_rdy[0]), 64'd1);
      check({tag, ":rst_resp_val"}, 64'(resp_val[0]), 64'd0);
      check({tag, ":rst_resp_msg"}, 64'(resp_msg[0]), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      resp_rdy[0] = 1'b1;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (resp_val[0] === 1'b1) seen++;
      end
      resp_rdy[0] = 1'b0;
      check({tag, ":no_resp"}, 64'(seen), 64'd0);
   endtask

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      mem_resp_4B_t got;
      mem_resp_4B_t exp_q[$];
      int           acc_q[$];
      int           last_acc;
      int           n_acc;
      bit           accepted;

      reset = 1'b0;
      for (int s = 0; s < 2; s++) begin
         req_val[s]  = 1'b0;
         resp_rdy[s] = 1'b0;
         req_msg[s]  = '0;
      end

      // Outputs while reset is held, independent of clock edges
      #12;
      for (int s = 0; s < 2; s++) begin
         check($sformatf("reset%0d:req_rdy", s), 64'(req_rdy[s]), 64'd1);
         check($sformatf("reset%0d:resp_val", s), 64'(resp_val[s]), 64'd0);
         check($sformatf("reset%0d:resp_msg", s), 64'(resp_msg[s]), 64'd0);
      end
      @(negedge clk);
      reset = 1'b1;

      // Fill every word so later random reads have defined contents
      for (int s = 0; s < 2; s++) begin
         for (int w = 0; w < NW; w++) begin
            txn(s, mk(3'd1, 8'(w), 32'(4 * w), 2'd0, 32'($urandom)), 0,
                $sformatf("init%0d", s), got);
         end
      end

      // Full-word write then read-back
      txn(0, mk(3'd1, 8'h05, 32'h10, 2'd0, 32'hDEADBEEF), 0, "wr_10", got);
      check("wr_10:type", 64'(got.type_), 64'd1);
      check("wr_10:opaque", 64'(got.opaque), 64'h05);
      check("wr_10:data", 64'(got.data), 64'd0);
      txn(0, mk(3'd0, 8'h06, 32'h10, 2'd0, 32'd0), 0, "rd_10", got);
      check("rd_10:data", 64'(got.data), 64'hDEADBEEF);

      // Single byte write into lane 2, then full and sub-word reads
      txn(0, mk(3'd1, 8'h07, 32'h12, 2'd1, 32'h000000AA), 0, "wr_12", got);
      txn(0, mk(3'd0, 8'h08, 32'h10, 2'd0, 32'd0), 0, "rd_10b", got);
      check("rd_10b:data", 64'(got.data), 64'hDEAABEEF);
      txn(0, mk(3'd0, 8'h09, 32'h13, 2'd1, 32'd0), 0, "rd_13", got);
      check("rd_13:data", 64'(got.data), 64'h000000DE);

      // Address wrap-around
      txn(0, mk(3'd1, 8'h0A, 32'h400, 2'd0, 32'h12345678), 0, "wr_400", got);
      txn(0, mk(3'd0, 8'h0B, 32'h0, 2'd0, 32'd0), 0, "rd_0", got);
      check("rd_0:data", 64'(got.data), 64'h12345678);

      // Unknown request type behaves as a read and is echoed back
      txn(0, mk(3'd1, 8'h0C, 32'h20, 2'd0, 32'hCAFEF00D), 0, "wr_20", got);
      txn(0, mk(3'd2, 8'h0D, 32'h20, 2'd0, 32'hFFFFFFFF), 0, "rd_t2", got);
      check("rd_t2:data", 64'(got.data), 64'hCAFEF00D);
      check("rd_t2:type", 64'(got.type_), 64'd2);

      // Accesses crossing the word boundary are truncated, not wrapped
      txn(0, mk(3'd1, 8'h0E, 32'h23, 2'd3, 32'h00332211), 0, "wr_23", got);
      txn(0, mk(3'd0, 8'h0F, 32'h20, 2'd0, 32'd0), 0, "rd_20", got);
      check("rd_20:data", 64'(got.data), 64'h11FEF00D);
      txn(0, mk(3'd0, 8'h10, 32'h24, 2'd0, 32'd0), 0, "rd_24", got);
      txn(0, mk(3'd0, 8'h11, 32'h22, 2'd3, 32'd0), 0, "rd_22", got);
      check("rd_22:data", 64'(got.data), 64'h000011FE);

      // Response backpressure for five cycles
      txn(0, mk(3'd0, 8'h12, 32'h10, 2'd0, 32'd0), 5, "bp", got);
      check("bp:data", 64'(got.data), 64'hDEAABEEF);

      // Reset during WAIT: read aborted, write already committed
      abort_in_wait(mk(3'd0, 8'h13, 32'h10, 2'd0, 32'd0), "abort_rd");
      txn(0, mk(3'd0, 8'h14, 32'h10, 2'd0, 32'd0), 0, "post_rst_rd", got);
      check("post_rst_rd:data", 64'(got.data), 64'hDEAABEEF);
      abort_in_wait(mk(3'd1, 8'h15, 32'h30, 2'd0, 32'h0BADC0DE), "abort_wr");
      txn(0, mk(3'd0, 8'h16, 32'h30, 2'd0, 32'd0), 0, "kept_wr", got);
      check("kept_wr:data", 64'(got.data), 64'h0BADC0DE);

      // Randomised traffic on both latencies
      for (int s = 0; s < 2; s++) begin
         for (int k = 0; k < 150; k++) begin
            txn(s, rand_req(), $urandom_range(0, 2), $sformatf("rand%0d", s), got);
         end
      end

      // Back-to-back reads on the zero-latency responder
      resp_rdy[1] = 1'b1;
      req_val[1]  = 1'b1;
      req_msg[1]  = mk(3'd0, 8'($urandom), 32'($urandom), 2'($urandom), 32'd0);
      last_acc    = -1;
      n_acc       = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (resp_val[1] === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("b2b:unexpected_resp", 64'(resp_val[1]), 64'd0);
            end else begin
               check("b2b:resp", 64'(resp_msg[1]), 64'(exp_q.pop_front()));
               check("b2b:latency", 64'(cyc - acc_q.pop_front()), 64'd1);
            end
         end
         accepted = (req_rdy[1] === 1'b1);
         if (accepted) begin
            if (last_acc >= 0) check("b2b:spacing", 64'(cyc - last_acc), 64'd2);
            last_acc = cyc;
            n_acc++;
            exp_q.push_back(model(1, req_msg[1]));
            acc_q.push_back(cyc);
         end
         @(posedge clk);
         #1;
         if (accepted) begin
            req_msg[1] = mk(3'd0, 8'($urandom), 32'($urandom), 2'($urandom), 32'd0);
         end
      end
      req_val[1] = 1'b0;
      @(negedge clk);
      resp_rdy[1] = 1'b0;
      check("b2b:accept_count", 64'(n_acc), 64'd20);
      check("b2b:drained", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/lab2_proc_mem_responder.md
LAB2_PROC_MEM_RESPONDER -- requirements
Module: lab2_proc_mem_responder

Interface
REQ-001 The block SHALL have parameter p_mem_nwords, default 256, meaning the number of 32-bit words; it SHALL be a power of 2 from 4 to 4096.
REQ-002 The block SHALL have parameter p_latency, default 2, meaning extra wait cycles before a response; legal range 0..15.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port reqstream_val, input, 1 bit: the request is valid.
REQ-006 Port reqstream_rdy, output, 1 bit: the responder accepts a request.
REQ-007 Port reqstream_msg, input, mem_req_4B_t: fields type (0=read, 1=write), opaque, addr, len, data.
REQ-008 Port respstream_val, output, 1 bit: the response is valid.
REQ-009 Port respstream_rdy, input, 1 bit: the consumer accepts the response.
REQ-010 Port respstream_msg, output, mem_resp_4B_t: fields type, opaque, test, len, data.

Function
REQ-011 A transfer on either stream SHALL occur only in a cycle where val and rdy are both 1 at the rising edge.
REQ-012 The FSM SHALL have the states IDLE, WAIT and RESP; only one request SHALL be outstanding at a time.
REQ-013 In IDLE:
- reqstream_rdy SHALL be 1.
- On an accepted request, the next state SHALL be WAIT if p_latency>0, and RESP if p_latency=0.
- On an accepted request with p_latency>0, the wait counter SHALL load p_latency-1.
REQ-014 In WAIT:
- reqstream_rdy SHALL be 0.
- The counter SHALL decrement each cycle.
- The FSM SHALL go to RESP on the cycle the counter is 0.
REQ-015 In RESP:
- respstream_val SHALL be 1 and reqstream_rdy SHALL be 0.
- The FSM SHALL return to IDLE on the cycle respstream_rdy=1.
- The FSM SHALL hold RESP, with the response message stable, while respstream_rdy=0.
REQ-016 respstream_val SHALL first be 1 exactly p_latency+1 cycles after the acceptance edge.
REQ-017 The word index SHALL be addr[log2(p_mem_nwords)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo 4*p_mem_nwords.
REQ-018 Byte count n SHALL be 4 when len=0 and len otherwise; the byte offset o SHALL be addr[1:0].
REQ-019 The active bytes SHALL be o .. min(o+n,4)-1; bytes crossing the word boundary SHALL be discarded and SHALL NOT wrap into the next word.
REQ-020 A write SHALL update only the active bytes, taken from data[8n-1:0] with data byte 0 going to byte lane o.
- The update SHALL happen at the acceptance edge.
- The response data for a write SHALL be 0.
REQ-021 A read SHALL capture the active bytes at the acceptance edge.
- Captured bytes SHALL be shifted to bit 0 and zero-extended.
- Because capture is at the acceptance edge, a read accepted after a write to the same address SHALL return the written value.
REQ-022 Response type, opaque and len SHALL equal the request fields; test SHALL be 2'b00.
REQ-023 Request types other than 0 and 1 SHALL be treated as reads.
REQ-024 A request presented while reqstream_rdy=0 SHALL NOT be consumed; the source holds it until accepted.
REQ-025 In RESP with respstream_rdy=1, the next request SHALL be accepted no earlier than the following cycle, which is IDLE; minimum spacing between acceptances is therefore p_latency+2 cycles.

Reset
REQ-026 While reset=0, regardless of clk:
- The FSM SHALL be in IDLE and the counter SHALL be 0.
- reqstream_rdy SHALL be 1 and respstream_val SHALL be 0.
- respstream_msg SHALL be all-zero.
REQ-027 Assertion of reset during WAIT or RESP SHALL abort the transaction with no response.
- A write already accepted SHALL remain in memory.
- Memory contents SHALL NOT be cleared by reset.
REQ-028 After reset deasserts, the first request SHALL be accepted on the first rising edge with reqstream_val=1.

Verification
REQ-029 p_latency=2:
- Stimulus: write addr 0x10, len 0, data 0xDEADBEEF, opaque 0x05; then read 0x10.
- Response 1: type 1, opaque 0x05, data 0, with val 3 cycles after acceptance.
- Response 2: data 0xDEADBEEF.
REQ-030 Starting from word 0x10 = 0xDEADBEEF:
- Stimulus: write addr 0x12, len 1, data 0x000000AA; then read 0x10 len 0 and read 0x13 len 1.
- Required responses: 0xDEAABEEF, then 0x000000DE.
REQ-031 p_mem_nwords=256:
- Stimulus: write addr 0x400 with data 0x12345678; then read addr 0x0.
- Required response: 0x12345678, showing wrap-around.
REQ-032 Backpressure: hold respstream_rdy=0 for 5 cycles in RESP.
- respstream_val SHALL stay 1 with the message unchanged.
- reqstream_rdy SHALL stay 0.
- The FSM SHALL return to IDLE the cycle after respstream_rdy=1.
REQ-033 Reset in WAIT:
- Stimulus: assert reset=0 asynchronously mid-cycle while in WAIT.
- reqstream_rdy SHALL go to 1 and respstream_val SHALL go to 0 before the next edge.
- No response SHALL ever appear for the aborted request.
REQ-034 p_latency=0 back-to-back reads with respstream_rdy held at 1:
- Each response SHALL appear 1 cycle after its acceptance.
- Acceptances SHALL occur every 2 cycles.
